// File: rtl/adc_sequencer_if.sv
// Handshake bundle around adc_sequencer: register command stream, SPI controller
// trigger/done pairs and the outgoing sample stream.
// master = sequencer side; slave = command source, SPI controller and sample sink.
interface adc_sequencer_if;
    logic [23:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        start_acq;
    logic        start_reg_wrt;
    logic [23:0] reg_cmd;
    logic        acq_done;
    logic        reg_wrt_done;
    logic [31:0] cnv_data;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    modport master (
        input  cmd_data, cmd_valid, acq_done, reg_wrt_done, cnv_data, m_tready,
        output cmd_ready, start_acq, start_reg_wrt, reg_cmd, m_tdata, m_tvalid
    );

    modport slave (
        output cmd_data, cmd_valid, acq_done, reg_wrt_done, cnv_data, m_tready,
        input  cmd_ready, start_acq, start_reg_wrt, reg_cmd, m_tdata, m_tvalid
    );
endinterface

// File: rtl/adc_sequencer.sv
// Timing master for one ADC channel: periodic CNV pulse, conversion wait, SPI readout
// trigger, single-entry sample buffer, and register writes slotted between conversions.
// Ports: clk/reset, enable/period (sampling), cnv (to ADC), link (command, SPI, sample
// stream), missed_count/overflow/timeout status with clear. All outputs registered.
module adc_sequencer #(
    parameter int unsigned CNV_PULSE_CYCLES = 4,
    parameter int unsigned CONV_WAIT_CYCLES = 30,
    parameter int unsigned MIN_PERIOD       = 64,
    parameter int unsigned REG_GUARD_CYCLES = 40,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [31:0]            period,
    output logic                   cnv,
    adc_sequencer_if.master        link,
    output logic [15:0]            missed_count,
    output logic                   overflow,
    output logic                   timeout,
    input  logic                   clear
);

    localparam logic [31:0] MIN_P      = 32'(MIN_PERIOD);
    localparam logic [31:0] GUARD      = 32'(REG_GUARD_CYCLES);
    localparam logic [31:0] PULSE_LAST = 32'(CNV_PULSE_CYCLES - 1);
    localparam logic [31:0] WAIT_LAST  = 32'(CONV_WAIT_CYCLES - 1);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CNV_HIGH,
        CNV_WAIT,
        ACQ,
        REG_WRT
    } state_t;

    state_t      state;
    logic [31:0] count;          // position inside the current sample period
    logic [31:0] p_reg;          // period latched at the last tick
    logic [31:0] timer;          // phase timer for CNV_HIGH/CNV_WAIT, watchdog in ACQ/REG_WRT

    logic [31:0] period_clamped;
    logic [31:0] p_cur;
    logic        tick;
    logic        guard_ok;
    logic        out_full;
    logic        ovf_set;
    logic        tmo_set;
    logic        missed_tick;

    always_comb begin
        period_clamped = (period < MIN_P) ? MIN_P : period;
        tick           = enable && (count == 32'd0);
        // The period applies from its own tick, so the wrap compare uses the fresh value.
        p_cur          = tick ? period_clamped : p_reg;
        // Only start a write when it cannot still be running when the next tick lands.
        guard_ok       = !enable || ((p_reg - count) > GUARD);
        out_full       = link.m_tvalid && !link.m_tready;
        ovf_set        = (state == ACQ) && link.acq_done && out_full;
        tmo_set        = (timer == TMO_LAST) &&
                         (((state == ACQ) && !link.acq_done) ||
                          ((state == REG_WRT) && !link.reg_wrt_done));
        missed_tick    = tick && (state != IDLE);
    end

    // Period counter: held at zero while disabled so the first enabled cycle ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 32'd0;
            p_reg <= MIN_P;
        end else if (!enable) begin
            count <= 32'd0;
        end else begin
            if (tick) begin
                p_reg <= period_clamped;
            end
            if (count == p_cur - 32'd1) begin
                count <= 32'd0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            timer              <= 32'd0;
            cnv                <= 1'b0;
            link.start_acq     <= 1'b0;
            link.start_reg_wrt <= 1'b0;
            link.cmd_ready     <= 1'b0;
            link.reg_cmd       <= 24'd0;
            link.m_tdata       <= 32'd0;
            link.m_tvalid      <= 1'b0;
        end else begin
            link.start_acq     <= 1'b0;
            link.start_reg_wrt <= 1'b0;
            link.cmd_ready     <= 1'b0;
            if (link.m_tvalid && link.m_tready) begin
                link.m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    timer <= 32'd0;
                    if (tick) begin
                        // A conversion always beats a pending command in the same cycle.
                        cnv   <= 1'b1;
                        state <= CNV_HIGH;
                    end else if (link.cmd_valid && guard_ok) begin
                        link.cmd_ready     <= 1'b1;
                        link.reg_cmd       <= link.cmd_data;
                        link.start_reg_wrt <= 1'b1;
                        state              <= REG_WRT;
                    end
                end

                CNV_HIGH: begin
                    if (timer == PULSE_LAST) begin
                        cnv   <= 1'b0;
                        timer <= 32'd0;
                        state <= CNV_WAIT;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                CNV_WAIT: begin
                    if (timer == WAIT_LAST) begin
                        link.start_acq <= 1'b1;
                        timer          <= 32'd0;
                        state          <= ACQ;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                ACQ: begin
                    if (link.acq_done) begin
                        // A stalled buffer keeps the oldest sample; the new one is lost.
                        if (!out_full) begin
                            link.m_tdata  <= link.cnv_data;
                            link.m_tvalid <= 1'b1;
                        end
                        timer <= 32'd0;
                        state <= IDLE;
                    end else if (timer == TMO_LAST) begin
                        timer <= 32'd0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                REG_WRT: begin
                    if (link.reg_wrt_done || (timer == TMO_LAST)) begin
                        timer <= 32'd0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                default: begin
                    cnv   <= 1'b0;
                    timer <= 32'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags: clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (reset) begin
            missed_count <= 16'd0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
        end else if (clear) begin
            missed_count <= 16'd0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (tmo_set) begin
                timeout <= 1'b1;
            end
            if (missed_tick && (missed_count != 16'hFFFF)) begin
                missed_count <= missed_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: SPI controller model, sample scoreboard,
// command source and cnv/start_acq timing monitor, one task per scenario.
// Ports: all DUT ports driven/observed; the handshake bundle is an interface instance.
module tb_adc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] period;
    logic        cnv;
    logic [15:0] missed_count;
    logic        overflow;
    logic        timeout;
    logic        clear;

    adc_sequencer_if link();

    adc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .cnv          (cnv),
        .link         (link),
        .missed_count (missed_count),
        .overflow     (overflow),
        .timeout      (timeout),
        .clear        (clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // cnv / start_acq timing monitor
    int   rise_q[$];
    int   hilen_q[$];
    int   sacq_q[$];
    logic cnv_d = 1'b0;
    int   hi_len = 0;

    always @(negedge clk) begin
        if (cnv === 1'b1 && cnv_d !== 1'b1) begin
            rise_q.push_back(cyc);
            hi_len = 0;
        end
        if (cnv === 1'b1) hi_len++;
        if (cnv !== 1'b1 && cnv_d === 1'b1) hilen_q.push_back(hi_len);
        if (link.start_acq === 1'b1) sacq_q.push_back(cyc);
        cnv_d = cnv;
    end

    // SPI controller model, sample sink and scoreboard
    bit          ready_mode = 1'b1;
    bit          ghost_next = 1'b0;
    bit          cur_ghost  = 1'b0;
    bit          exp_full   = 1'b0;
    logic [31:0] sb_q[$];
    logic [23:0] exp_cmd    = 24'd0;
    int          acq_cnt    = 0;
    int          reg_cnt    = 0;
    int          pops       = 0;
    int          spurious   = 0;
    int          overlap    = 0;

    always @(negedge clk) begin
        bit hs;
        bit drop;
        bit fire;
        link.m_tready = ready_mode;
        if (reset === 1'b1) begin
            exp_full          = 1'b0;
            acq_cnt           = 0;
            reg_cnt           = 0;
            link.acq_done     = 1'b0;
            link.reg_wrt_done = 1'b0;
            link.cnv_data     = 32'd0;
        end else begin
            if (link.m_tvalid === 1'b1 && !exp_full) spurious++;
            if (link.start_acq === 1'b1 && link.start_reg_wrt === 1'b1) overlap++;
            hs   = exp_full && ready_mode;
            drop = exp_full && !ready_mode;
            if (hs) begin
                checks++;
                if (link.m_tvalid !== 1'b1 || link.m_tdata !== sb_q[0])
                    $display("FAIL sample: m_tvalid=%0b m_tdata=%08h, expected 1 and %08h",
                             link.m_tvalid, link.m_tdata, sb_q[0]);
                else passed++;
                void'(sb_q.pop_front());
                pops++;
                exp_full = 1'b0;
            end

            fire = 1'b0;
            link.acq_done = 1'b0;
            if (acq_cnt > 0) begin
                acq_cnt--;
                if (acq_cnt == 0) fire = 1'b1;
            end
            if (link.start_acq === 1'b1) begin
                cur_ghost  = ghost_next;
                ghost_next = 1'b0;
                acq_cnt    = cur_ghost ? 260 : 20;
            end
            if (fire) begin
                link.acq_done = 1'b1;
                link.cnv_data = $urandom;
                if (!cur_ghost && !drop) begin
                    sb_q.push_back(link.cnv_data);
                    exp_full = 1'b1;
                end
            end

            link.reg_wrt_done = 1'b0;
            if (reg_cnt > 0) begin
                reg_cnt--;
                if (reg_cnt == 0) link.reg_wrt_done = 1'b1;
            end
            if (link.start_reg_wrt === 1'b1) begin
                checks++;
                if (link.reg_cmd !== exp_cmd || link.cmd_ready !== 1'b1)
                    $display("FAIL reg_issue: reg_cmd=%06h cmd_ready=%0b, expected %06h and 1",
                             link.reg_cmd, link.cmd_ready, exp_cmd);
                else passed++;
                reg_cnt = 5;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_rise(output int r);
        int n = rise_q.size();
        r = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (rise_q.size() > n) begin
                r = rise_q[$];
                break;
            end
        end
        if (r < 0) begin
            checks++;
            $display("FAIL wait_rise: no cnv pulse within 400 cycles");
        end
    endtask

    task automatic send_cmd(input logic [23:0] d, output int acc);
        exp_cmd        = d;
        link.cmd_data  = d;
        link.cmd_valid = 1'b1;
        acc            = -1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (link.cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        link.cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            $display("FAIL cmd_accept: no cmd_ready within 300 cycles");
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({cnv, link.start_acq, link.start_reg_wrt, link.cmd_ready, link.m_tvalid, overflow, timeout} !== 7'd0)
            $display("FAIL reset_ctrl: cnv/start_acq/start_reg_wrt/cmd_ready/m_tvalid/overflow/timeout=%07b, expected 0",
                     {cnv, link.start_acq, link.start_reg_wrt, link.cmd_ready, link.m_tvalid, overflow, timeout});
        else passed++;
        checks++;
        if (link.reg_cmd !== 24'd0 || link.m_tdata !== 32'd0)
            $display("FAIL reset_data: reg_cmd=%06h m_tdata=%08h, expected 0", link.reg_cmd, link.m_tdata);
        else passed++;
        checks++;
        if (missed_count !== 16'd0)
            $display("FAIL reset_missed: got %0d expected 0", missed_count);
        else passed++;
        reset = 1'b0;
        repeat (20) step();
        checks++;
        if (rise_q.size() !== 0)
            $display("FAIL disabled_no_cnv: got %0d pulses expected 0", rise_q.size());
        else passed++;
    endtask

    task automatic test_reg_idle();
        int c0;
        int acc;
        c0 = cyc;
        send_cmd(24'hA5C3E1, acc);
        checks++;
        if (acc !== c0 + 1)
            $display("FAIL reg_idle_accept: cmd_ready at cycle %0d expected %0d", acc, c0 + 1);
        else passed++;
        repeat (10) step();
    endtask

    task automatic test_timing();
        int c0;
        period = 32'd100;
        rise_q.delete();
        hilen_q.delete();
        sacq_q.delete();
        c0 = cyc;
        enable = 1'b1;
        repeat (250) step();
        checks++;
        if (rise_q.size() < 3 || sacq_q.size() < 3 || hilen_q.size() < 3)
            $display("FAIL timing_counts: rises=%0d start_acqs=%0d, expected at least 3", rise_q.size(), sacq_q.size());
        else passed++;
        checks++;
        if (rise_q[0] !== c0 + 1)
            $display("FAIL first_tick: cnv rose at %0d expected %0d", rise_q[0], c0 + 1);
        else passed++;
        checks++;
        if (hilen_q[0] !== 4 || hilen_q[1] !== 4)
            $display("FAIL cnv_width: got %0d,%0d expected 4", hilen_q[0], hilen_q[1]);
        else passed++;
        checks++;
        if (sacq_q[0] - rise_q[0] !== 34 || sacq_q[1] - rise_q[1] !== 34)
            $display("FAIL start_acq_delay: got %0d,%0d expected 34", sacq_q[0] - rise_q[0], sacq_q[1] - rise_q[1]);
        else passed++;
        checks++;
        if (rise_q[1] - rise_q[0] !== 100 || rise_q[2] - rise_q[1] !== 100)
            $display("FAIL period_100: spacing %0d,%0d expected 100", rise_q[1] - rise_q[0], rise_q[2] - rise_q[1]);
        else passed++;
        checks++;
        if (pops < 2)
            $display("FAIL samples_delivered: got %0d expected at least 2", pops);
        else passed++;
    endtask

    task automatic test_clamp();
        period = 32'd10;
        repeat (150) step();
        rise_q.delete();
        repeat (140) step();
        checks++;
        if (rise_q.size() < 2 || rise_q[1] - rise_q[0] !== 64)
            $display("FAIL period_clamp: spacing %0d expected 64", rise_q[1] - rise_q[0]);
        else passed++;
        period = 32'd100;
    endtask

    task automatic test_reg_placement(output int t_out);
        int r;
        int t;
        int acc;
        wait_rise(r);
        t = r - 1;
        wait_until(t + 59);
        send_cmd(24'h123456, acc);
        checks++;
        if (acc !== t + 60)
            $display("FAIL reg_guard_41: accepted at %0d expected %0d", acc, t + 60);
        else passed++;
        wait_rise(r);
        t = r - 1;
        wait_until(t + 60);
        send_cmd(24'h654321, acc);
        checks++;
        if (acc !== t + 157)
            $display("FAIL reg_guard_40: accepted at %0d expected %0d", acc, t + 157);
        else passed++;
        t_out = t;
    endtask

    task automatic test_tick_collision(input int t);
        int acc;
        wait_until(t + 200);
        send_cmd(24'hBEEF01, acc);
        checks++;
        if (acc !== t + 257)
            $display("FAIL collision_cmd: accepted at %0d expected %0d", acc, t + 257);
        else passed++;
        checks++;
        if (rise_q[$] !== t + 201)
            $display("FAIL collision_cnv: cnv rose at %0d expected %0d", rise_q[$], t + 201);
        else passed++;
    endtask

    task automatic test_timeout();
        int r;
        int r2;
        int t;
        pulse_clear();
        wait_rise(r);
        t = r - 1;
        ghost_next = 1'b1;
        wait_until(t + 285);
        checks++;
        if (timeout !== 1'b0)
            $display("FAIL timeout_early: got %0b expected 0", timeout);
        else passed++;
        wait_until(t + 295);
        checks++;
        if (timeout !== 1'b1)
            $display("FAIL timeout_set: got %0b expected 1", timeout);
        else passed++;
        checks++;
        if (missed_count !== 16'd2)
            $display("FAIL missed_count: got %0d expected 2", missed_count);
        else passed++;
        wait_rise(r2);
        checks++;
        if (r2 !== t + 301)
            $display("FAIL tick_after_timeout: cnv rose at %0d expected %0d", r2, t + 301);
        else passed++;
        repeat (60) step();
        pulse_clear();
        checks++;
        if (timeout !== 1'b0 || missed_count !== 16'd0)
            $display("FAIL clear_status: timeout=%0b missed=%0d expected 0 and 0", timeout, missed_count);
        else passed++;
    endtask

    task automatic test_backpressure();
        int r;
        int p0;
        wait_rise(r);
        ready_mode = 1'b0;
        wait_rise(r);
        wait_rise(r);
        wait_until(r + 60);
        checks++;
        if (overflow !== 1'b1 || link.m_tvalid !== 1'b1)
            $display("FAIL overflow_set: overflow=%0b m_tvalid=%0b expected 1 and 1", overflow, link.m_tvalid);
        else passed++;
        pulse_clear();
        checks++;
        if (overflow !== 1'b0)
            $display("FAIL overflow_clear: got %0b expected 0", overflow);
        else passed++;
        p0 = pops;
        ready_mode = 1'b1;
        repeat (3) step();
        checks++;
        if (pops !== p0 + 1 || sb_q.size() !== 0)
            $display("FAIL held_sample: delivered %0d pending %0d expected 1 and 0", pops - p0, sb_q.size());
        else passed++;
    endtask

    task automatic test_disable_mid();
        int r;
        int p0;
        int n;
        wait_rise(r);
        wait_until(r + 10);
        enable = 1'b0;
        p0 = pops;
        n = rise_q.size();
        repeat (150) step();
        checks++;
        if (pops !== p0 + 1)
            $display("FAIL disable_mid_sample: delivered %0d expected 1", pops - p0);
        else passed++;
        checks++;
        if (rise_q.size() !== n)
            $display("FAIL disable_no_tick: extra pulses %0d expected 0", rise_q.size() - n);
        else passed++;
    endtask

    initial begin
        int t;
        reset          = 1'b1;
        enable         = 1'b0;
        period         = 32'd100;
        clear          = 1'b0;
        link.cmd_valid = 1'b0;
        link.cmd_data  = 24'd0;
        repeat (3) step();
        test_reset();
        test_reg_idle();
        test_timing();
        test_clamp();
        test_reg_placement(t);
        test_tick_collision(t);
        test_timeout();
        test_backpressure();
        test_disable_mid();
        checks++;
        if (overlap !== 0)
            $display("FAIL start_overlap: got %0d cycles expected 0", overlap);
        else passed++;
        checks++;
        if (spurious !== 0)
            $display("FAIL spurious_sample: got %0d cycles expected 0", spurious);
        else passed++;
        checks++;
        if (sb_q.size() !== 0)
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
